// File: rtl/reduce_config_sequencer.sv
// Reprograms per-chain firmware of a reduce-unit bank from a shadow table.
// Define SKIP_UNCHANGED_EN to stream only entries written since their last push.
module reduce_config_sequencer #(
  parameter int NUM_UNITS       = 4,
  parameter int MAX_CHAINS      = 4,
  parameter int FIRST_CONFIG_ID = 0,
  parameter int DRAIN_CYCLES    = 4,
  localparam int N  = NUM_UNITS * MAX_CHAINS,
  localparam int AW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1,
  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          tbl_we,
  input  logic [AW-1:0] tbl_addr,
  input  logic [7:0]    tbl_data,
  input  logic          valid_in,
  output logic          busy,
  output logic          done,
  output logic          tbl_err,
  output logic          tracing,
  output logic [7:0]    configId,
  output logic [CW-1:0] chainId,
  output logic [7:0]    configData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_WRITE,
    S_RESUME
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [7:0]    tbl_q [N];
  logic [7:0]    tbl_d [N];
  logic          tbl_err_q, tbl_err_d;
  logic          busy_w;

`ifdef SKIP_UNCHANGED_EN
  logic [N-1:0]  dirty_q, dirty_d;
  logic          any_dirty;
  logic [AW-1:0] first_idx;
  logic          nxt_found;
  logic [AW-1:0] nxt_idx;

  // Lowest dirty index overall, and lowest dirty index above the cursor.
  always_comb begin
    any_dirty = |dirty_q;
    first_idx = '0;
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (dirty_q[i]) begin
        first_idx = i[AW-1:0];
        if (i > int'(cur_q)) begin
          nxt_found = 1'b1;
          nxt_idx   = i[AW-1:0];
        end
      end
    end
  end
`endif

  assign busy_w = (state_q == S_DRAIN) || (state_q == S_WRITE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    cur_d     = cur_q;
    tbl_d     = tbl_q;
    tbl_err_d = 1'b0;
`ifdef SKIP_UNCHANGED_EN
    dirty_d   = dirty_q;
`endif

    if (tbl_we) begin
      if (busy_w) begin
        tbl_err_d = 1'b1;
      end else if (int'(tbl_addr) < N) begin
        tbl_d[tbl_addr] = tbl_data;
`ifdef SKIP_UNCHANGED_EN
        dirty_d[tbl_addr] = 1'b1;
`endif
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (int'(cnt_q) == DRAIN_CYCLES) begin
`ifdef SKIP_UNCHANGED_EN
          if (any_dirty) begin
            state_d = S_WRITE;
            cur_d   = first_idx;
          end else begin
            state_d = S_RESUME;
          end
`else
          state_d = S_WRITE;
          cur_d   = '0;
`endif
        end else begin
          cnt_d = valid_in ? '0 : cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
`ifdef SKIP_UNCHANGED_EN
        dirty_d[cur_q] = 1'b0;
        if (nxt_found) cur_d = nxt_idx;
        else state_d = S_RESUME;
`else
        if (int'(cur_q) == N - 1) state_d = S_RESUME;
        else cur_d = cur_q + 1'b1;
`endif
      end
      S_RESUME: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cur_q     <= '0;
      tbl_err_q <= 1'b0;
      tbl_q     <= '{default: '0};
`ifdef SKIP_UNCHANGED_EN
      dirty_q   <= '1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      tbl_err_q <= tbl_err_d;
      tbl_q     <= tbl_d;
`ifdef SKIP_UNCHANGED_EN
      dirty_q   <= dirty_d;
`endif
    end
  end

  // Bus is parked at 8'hFF whenever no entry is being pushed.
  always_comb begin
    configId   = 8'hFF;
    chainId    = '0;
    configData = '0;
    if (state_q == S_WRITE) begin
      configId   = 8'(FIRST_CONFIG_ID + int'(cur_q) / MAX_CHAINS);
      chainId    = CW'(int'(cur_q) % MAX_CHAINS);
      configData = tbl_q[cur_q];
    end
  end

  assign busy    = busy_w;
  assign tracing = !busy_w;
  assign done    = (state_q == S_RESUME);
  assign tbl_err = tbl_err_q;

endmodule

// File: tb/tb_reduce_config_sequencer.sv
// Bench for reduce_config_sequencer: directed steps with random drain traffic,
// checked against a table/queue model of the programming sequence.
module tb_reduce_config_sequencer;

  localparam int NU  = 4;
  localparam int MC  = 4;
  localparam int FID = 0;
  localparam int DC  = 4;
  localparam int N   = NU * MC;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       tbl_we;
  logic [3:0] tbl_addr;
  logic [7:0] tbl_data;
  logic       valid_in;
  logic       busy;
  logic       done;
  logic       tbl_err;
  logic       tracing;
  logic [7:0] configId;
  logic [1:0] chainId;
  logic [7:0] configData;

  int n_err = 0;
  int n_chk = 0;

  logic [7:0] m_tbl [N];
  bit         m_dirty [N];
  bit         vpat [256];

  typedef struct {
    int id;
    int ch;
    int data;
  } bus_t;

  reduce_config_sequencer #(
    .NUM_UNITS      (NU),
    .MAX_CHAINS     (MC),
    .FIRST_CONFIG_ID(FID),
    .DRAIN_CYCLES   (DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tbl_we    (tbl_we),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .valid_in  (valid_in),
    .busy      (busy),
    .done      (done),
    .tbl_err   (tbl_err),
    .tracing   (tracing),
    .configId  (configId),
    .chainId   (chainId),
    .configData(configData)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_tbl[i]   = 8'h00;
      m_dirty[i] = 1'b1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tracing"}, tracing, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_tbl_err"}, tbl_err, 0);
    chk({tag, "_configId"}, configId, 8'hFF);
    chk({tag, "_chainId"}, chainId, 0);
    chk({tag, "_configData"}, configData, 0);
  endtask

  task automatic wr(input int a, input int d);
    tbl_we   = 1'b1;
    tbl_addr = 4'(a);
    tbl_data = 8'(d);
    tick();
    tbl_we     = 1'b0;
    m_tbl[a]   = 8'(d);
    m_dirty[a] = 1'b1;
    chk("wr_tbl_err", tbl_err, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_busy", busy, 0);
      chk("idle_configId", configId, 8'hFF);
      chk("idle_tracing", tracing, 1);
      tick();
    end
  endtask

  // mode: 0 quiet, 1 valid every 3rd cycle up to 12, 2 random, 3 stuck high
  task automatic run_seq(input int mode, input int w0_addr,
                         input int w0_data, input int inj_t,
                         input int rst_t);
    bus_t exp_q[$];
    int   w;
    int   k;
    int   done_t;
    bit   in_w;
    bit   quiet;

    for (int t = 0; t < 256; t++) begin
      case (mode)
        1: vpat[t] = (t >= 1 && t <= 12 && t % 3 == 0);
        2: vpat[t] = (t >= 1 && t <= 30) && ($urandom_range(0, 2) == 0);
        3: vpat[t] = (t >= 1 && t <= 40);
        default: vpat[t] = 1'b0;
      endcase
    end

    if (w0_addr >= 0) begin
      m_tbl[w0_addr]   = 8'(w0_data);
      m_dirty[w0_addr] = 1'b1;
    end

    for (int u = 0; u < NU; u++) begin
      for (int c = 0; c < MC; c++) begin
`ifdef SKIP_UNCHANGED_EN
        if (!m_dirty[u * MC + c]) continue;
`endif
        exp_q.push_back('{id: FID + u, ch: c,
                          data: int'(m_tbl[u * MC + c])});
        m_dirty[u * MC + c] = 1'b0;
      end
    end

    // Writing starts the cycle after DC idle cycles have been seen in DRAIN.
    w = 0;
    for (int t = DC + 1; t < 250; t++) begin
      quiet = 1'b1;
      for (int j = t - DC; j < t; j++) if (vpat[j]) quiet = 1'b0;
      if (quiet) begin
        w = t + 1;
        break;
      end
    end
    k      = exp_q.size();
    done_t = w + k;

    start    = 1'b1;
    valid_in = vpat[0];
    if (w0_addr >= 0) begin
      tbl_we   = 1'b1;
      tbl_addr = 4'(w0_addr);
      tbl_data = 8'(w0_data);
    end
    tick();
    start  = 1'b0;
    tbl_we = 1'b0;

    for (int t = 1; t <= done_t; t++) begin
      valid_in = vpat[t];
      start    = 1'b0;
      tbl_we   = 1'b0;
      if (t == inj_t) begin
        start    = 1'b1;
        tbl_we   = 1'b1;
        tbl_addr = 4'd5;
        tbl_data = ~m_tbl[5];
      end
      in_w = (t >= w) && (t < done_t);
      if (in_w) begin
        chk("bus_configId", configId, exp_q[t - w].id);
        chk("bus_chainId", chainId, exp_q[t - w].ch);
        chk("bus_configData", configData, exp_q[t - w].data);
      end else begin
        chk("park_configId", configId, 8'hFF);
      end
      chk("seq_tracing", tracing, (t == done_t));
      chk("seq_busy", busy, (t < done_t));
      chk("seq_done", done, (t == done_t));
      chk("seq_tbl_err", tbl_err, (inj_t > 0 && t == inj_t + 1));
      if (t == rst_t) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_reset_vals("abort");
        return;
      end
      tick();
    end
    start  = 1'b0;
    tbl_we = 1'b0;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_configId", configId, 8'hFF);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    tbl_we   = 1'b0;
    tbl_addr = '0;
    tbl_data = '0;
    valid_in = 1'b0;
    model_reset();
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b0;

    // zero table, quiet upstream: 16 writes, done 22 cycles after start
    run_seq(0, -1, 0, -1, -1);

    wr(5, 8'h01);
    run_seq(0, -1, 0, -1, -1);

    run_seq(1, -1, 0, -1, -1);

    // write and start in the same idle cycle
    run_seq(0, 10, 8'h3C, -1, -1);

    for (int i = 0; i < 6; i++) begin
      wr(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)));
    end
    run_seq(2, -1, 0, -1, -1);

    run_seq(3, -1, 0, -1, -1);

    // write and start during WRITE are rejected
    for (int i = 0; i < 8; i++) wr(i, int'($urandom_range(0, 255)));
    run_seq(0, -1, 0, 9, -1);
    idle(8);
    run_seq(0, -1, 0, -1, -1);

    // reset on the 5th WRITE cycle, then a full sequence from a clean table
    for (int i = 0; i < N; i++) wr(i, int'($urandom_range(1, 255)));
    run_seq(0, -1, 0, -1, 10);
    run_seq(0, -1, 0, -1, -1);

    wr(9, 8'hA5);
    run_seq(0, -1, 0, -1, -1);
    run_seq(2, -1, 0, -1, -1);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
